// File: rtl/lu_pkg.sv
// lu_pkg: shared opcode encoding for the logic unit, ALU result mux and decoder.
package lu_pkg;

   typedef enum logic [1:0] {
      LU_AND = 2'b00,
      LU_OR  = 2'b01,
      LU_XOR = 2'b10,
      LU_NOR = 2'b11
   } lu_op_e;

endpackage

// File: rtl/lu_core.sv
// lu_core: combinational WIDTH-bit bitwise function selected by opcode.
module lu_core
   import lu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  lu_op_e           op,
   output logic [WIDTH-1:0] f
);

   always_comb begin
      f = op == LU_AND ? a & b :
          op == LU_OR  ? a | b :
          op == LU_XOR ? a ^ b :
                         ~(a | b);
   end

endmodule

// File: rtl/lu.sv
// lu: registered bitwise logic unit with one-cycle latency, valid strobe and zero flag.
module lu
   import lu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             zero
);

   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] y_d, y_q;
   logic             zero_d, zero_q;
   logic             valid_d, valid_q;

   lu_core #(.WIDTH(WIDTH)) u_core (
      .a  (a),
      .b  (b),
      .op (lu_op_e'(op)),
      .f  (f)
   );

   // y and zero hold across idle cycles; only the strobe drops
   always_comb begin
      y_d     = in_valid ? f : y_q;
      zero_d  = in_valid ? ~|f : zero_q;
      valid_d = in_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q     <= '0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   assign y         = y_q;
   assign zero      = zero_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_lu.sv
// tb_lu: scoreboard bench for lu; expected results queued at issue, checked by a monitor.
module tb_lu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic [1:0]   op = '0;
   logic         in_valid = 1'b0;
   logic [W-1:0] y;
   logic         out_valid, zero;

   int errors = 0;
   int checks = 0;

   logic [W:0]   sb_q[$];
   logic         exp_valid = 1'b0;
   logic [W-1:0] hold_y = '0;
   logic         hold_zero = 1'b1;
   logic         armed = 1'b0;

   lu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .op        (op),
      .in_valid  (in_valid),
      .y         (y),
      .out_valid (out_valid),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_f(input logic [W-1:0] x, input logic [W-1:0] z, input logic [1:0] o);
      case (o)
         2'd0:    return x & z;
         2'd1:    return x | z;
         2'd2:    return x ^ z;
         default: return ~(x | z);
      endcase
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // issue side: what each edge should produce
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q.delete();
         exp_valid = 1'b0;
         hold_y    = '0;
         hold_zero = 1'b1;
         armed     = 1'b1;
      end else begin
         if (in_valid) sb_q.push_back({ref_f(a, b, op) == '0, ref_f(a, b, op)});
         exp_valid = in_valid;
      end
   end

   // monitor side
   always @(posedge clk) begin
      logic [W:0] e;
      #1;
      if (armed) begin
         check("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_valid});
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               hold_y    = e[W-1:0];
               hold_zero = e[W];
            end
         end
         check("y", y, hold_y);
         check("zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, hold_zero});
      end
   end

   task automatic drive(input logic [W-1:0] na, input logic [W-1:0] nb, input logic [1:0] nop, input logic nv);
      @(negedge clk);
      a = na; b = nb; op = nop; in_valid = nv;
   endtask

   task automatic async_reset_pulse();
      #2 rst = 1'b1;
      #1;
      check("rst_y", y, '0);
      check("rst_zero", {{(W-1){1'b0}}, zero}, 1);
      check("rst_out_valid", {{(W-1){1'b0}}, out_valid}, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      async_reset_pulse();
      repeat (3) drive('0, '0, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) drive(8'hF0, 8'hCC, 2'(i), 1'b1);
      drive(8'hAA, 8'hAA, 2'd2, 1'b1);
      drive(8'h00, 8'h00, 2'd3, 1'b1);
      drive(8'hF0, 8'hCC, 2'd0, 1'b1);
      drive(8'h0F, 8'h33, 2'd3, 1'b0);
      drive(8'h00, 8'h00, 2'd2, 1'b0);
      drive(8'hFF, 8'h01, 2'd1, 1'b0);
      for (int i = 0; i < 6; i++) drive(W'($urandom), W'($urandom), 2'($urandom), 1'b1);
      async_reset_pulse();
      for (int i = 0; i < 4; i++) begin
         a = W'($urandom); b = W'($urandom); op = 2'($urandom); in_valid = 1'b1;
         @(negedge clk);
      end
      for (int i = 0; i < 1000; i++)
         drive(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
      repeat (3) drive('0, '0, 2'd0, 1'b0);
      check("sb_drained", W'(sb_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
